// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the shared-memory MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives all
// datapath strobes combinationally from the current state, and counts
// retired instructions. Unsupported opcodes park the FSM in TRAP.
module mc_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        if_extend,
    output logic [4:0]  aluop,
    output logic        retire,
    output logic [31:0] instr_cnt,
    output logic        illegal,
    output logic [3:0]  state
);

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;
    localparam logic [4:0] ALU_LUI = 5'd5;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        MEM_RD = 4'd3,
        MEM_WR = 4'd4,
        WB     = 4'd5,
        BRANCH = 4'd6,
        JUMP   = 4'd7,
        TRAP   = 4'd8
    } state_t;

    state_t cur;

    logic is_rtype, rtype_ok, is_imm, is_lw, is_sw, is_beq, is_j, alu_path;
    logic [4:0] exec_aluop;

    assign is_rtype = (op == OP_R);
    assign rtype_ok = is_rtype && (funct == FN_ADDU || funct == FN_SUBU ||
                                   funct == FN_AND  || funct == FN_OR   ||
                                   funct == FN_SLT);
    assign is_imm   = (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    // Everything that runs through EXEC (ALU ops and address generation).
    assign alu_path = rtype_ok || is_imm || is_lw || is_sw;

    // ALU operation for EXEC, also held through WB so the result stays stable.
    always_comb begin
        exec_aluop = ALU_ADD;
        if (is_rtype) begin
            case (funct)
                FN_SUBU: exec_aluop = ALU_SUB;
                FN_AND:  exec_aluop = ALU_AND;
                FN_OR:   exec_aluop = ALU_OR;
                FN_SLT:  exec_aluop = ALU_SLT;
                default: exec_aluop = ALU_ADD;
            endcase
        end else if (op == OP_ORI) begin
            exec_aluop = ALU_OR;
        end else if (op == OP_LUI) begin
            exec_aluop = ALU_LUI;
        end
    end

    // State sequencing, retired-instruction counter and sticky trap flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur       <= FETCH;
            instr_cnt <= '0;
            illegal   <= 1'b0;
        end else begin
            if (retire) instr_cnt <= instr_cnt + 32'd1;
            case (cur)
                FETCH:  if (mem_ready) cur <= DECODE;
                DECODE: begin
                    if (alu_path)    cur <= EXEC;
                    else if (is_beq) cur <= BRANCH;
                    else if (is_j)   cur <= JUMP;
                    else begin
                        cur     <= TRAP;
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_lw)      cur <= MEM_RD;
                    else if (is_sw) cur <= MEM_WR;
                    else            cur <= WB;
                end
                MEM_RD: if (mem_ready) cur <= WB;
                MEM_WR: if (mem_ready) cur <= FETCH;
                WB, BRANCH, JUMP: cur <= FETCH;
                TRAP:    cur <= TRAP;
                default: cur <= FETCH;
            endcase
        end
    end

    // Datapath strobes; all held low while reset is asserted.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        if_extend  = 1'b0;
        aluop      = ALU_ADD;
        retire     = 1'b0;
        if (reset) begin
            case (cur)
                FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                EXEC: begin
                    alu_src   = !is_rtype;
                    if_extend = (op == OP_ADDIU) || is_lw || is_sw;
                    aluop     = exec_aluop;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_rtype;
                    mem_to_reg = is_lw;
                    alu_src    = !is_rtype;
                    aluop      = exec_aluop;
                    retire     = 1'b1;
                end
                BRANCH: begin
                    aluop    = ALU_SUB;
                    pc_src   = 2'd1;
                    pc_write = zero;
                    retire   = 1'b1;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed test of mc_ctrl. Each instruction is expanded into a
// per-cycle plan (inputs plus expected outputs) from the instruction-level
// rules; one compare process checks the DUT against that plan every cycle.
module tb_mc_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src, if_extend;
    logic        retire, illegal;
    logic [1:0]  pc_src;
    logic [4:0]  aluop;
    logic [31:0] instr_cnt;
    logic [3:0]  state;

    mc_ctrl dut (
        .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .if_extend(if_extend),
        .aluop(aluop), .retire(retire), .instr_cnt(instr_cnt),
        .illegal(illegal), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw, iod, mr, mw, rw, rd, m2r, as, ie;
        logic [4:0] aop;
        logic       ret;
    } exp_t;

    typedef struct {
        exp_t o;
        logic rdy;
    } cyc_t;

    cyc_t        plan[$];
    logic [3:0]  obs_st[$];
    exp_t        exp_cur;
    logic        exp_valid;
    logic [31:0] exp_cnt;
    logic        exp_ill;
    logic [4:0]  last_aop;
    logic        last_ie;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ALU code for an instruction, straight from the instruction table.
    function automatic logic [4:0] alu_for(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f == 6'h23) return 5'd1;
            if (f == 6'h24) return 5'd2;
            if (f == 6'h25) return 5'd3;
            if (f == 6'h2a) return 5'd4;
            return 5'd0;
        end
        if (o == 6'h0d) return 5'd3;
        if (o == 6'h0f) return 5'd5;
        return 5'd0;
    endfunction

    // Expand one instruction into its expected cycle sequence.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fw, input int mwait, input int trap_n);
        cyc_t c;
        logic r_ok;
        plan.delete();
        r_ok = (o == 6'h00) && (f == 6'h21 || f == 6'h23 || f == 6'h24 ||
                                f == 6'h25 || f == 6'h2a);
        for (int i = 0; i < fw; i++) begin
            c.o = '0; c.rdy = 1'b0; c.o.st = 4'd0; c.o.mr = 1'b1;
            plan.push_back(c);
        end
        c.o = '0; c.rdy = 1'b1; c.o.st = 4'd0; c.o.mr = 1'b1; c.o.irw = 1'b1; c.o.pcw = 1'b1;
        plan.push_back(c);
        c.o = '0; c.rdy = 1'b1; c.o.st = 4'd1;
        plan.push_back(c);
        if (o == 6'h04) begin
            c.o = '0; c.o.st = 4'd6; c.o.aop = 5'd1; c.o.pcs = 2'd1; c.o.pcw = z; c.o.ret = 1'b1;
            plan.push_back(c);
        end else if (o == 6'h02) begin
            c.o = '0; c.o.st = 4'd7; c.o.pcw = 1'b1; c.o.pcs = 2'd2; c.o.ret = 1'b1;
            plan.push_back(c);
        end else if (r_ok || o == 6'h09 || o == 6'h0d || o == 6'h0f || o == 6'h23 || o == 6'h2b) begin
            c.o = '0; c.o.st = 4'd2; c.o.as = (o != 6'h00);
            c.o.ie = (o == 6'h09 || o == 6'h23 || o == 6'h2b);
            c.o.aop = alu_for(o, f);
            plan.push_back(c);
            if (o == 6'h23) begin
                for (int i = 0; i <= mwait; i++) begin
                    c.o = '0; c.rdy = (i == mwait); c.o.st = 4'd3; c.o.mr = 1'b1; c.o.iod = 1'b1;
                    plan.push_back(c);
                end
                c.o = '0; c.rdy = 1'b1; c.o.st = 4'd5; c.o.rw = 1'b1; c.o.m2r = 1'b1;
                c.o.as = 1'b1; c.o.ret = 1'b1;
                plan.push_back(c);
            end else if (o == 6'h2b) begin
                for (int i = 0; i <= mwait; i++) begin
                    c.o = '0; c.rdy = (i == mwait); c.o.st = 4'd4; c.o.mw = 1'b1; c.o.iod = 1'b1;
                    c.o.ret = (i == mwait);
                    plan.push_back(c);
                end
            end else begin
                c.o = '0; c.rdy = 1'b1; c.o.st = 4'd5; c.o.rw = 1'b1; c.o.rd = (o == 6'h00);
                c.o.as = (o != 6'h00); c.o.aop = alu_for(o, f); c.o.ret = 1'b1;
                plan.push_back(c);
            end
        end else begin
            for (int i = 0; i < trap_n; i++) begin
                c.o = '0; c.rdy = 1'b1; c.o.st = 4'd8;
                plan.push_back(c);
            end
        end
    endtask

    // Drive up to n planned cycles (n<0: all), starting just after a clock edge.
    task automatic run_plan(input int n);
        for (int i = 0; i < plan.size() && (n < 0 || i < n); i++) begin
            mem_ready = plan[i].rdy;
            exp_cur   = plan[i].o;
            if (plan[i].o.st == 4'd8) exp_ill = 1'b1;
            exp_valid = 1'b1;
            @(posedge clock); #1;
            if (plan[i].o.ret) exp_cnt = exp_cnt + 32'd1;
        end
        exp_valid = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mwait);
        op = o; funct = f; zero = z;
        build(o, f, z, fw, mwait, 3);
        obs_st.delete();
        run_plan(-1);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_outs"}, 32'({pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                                reg_write, reg_dst, mem_to_reg, alu_src, if_extend,
                                aluop, retire, illegal, state}), 32'd0);
        chk({nm, "_cnt"}, instr_cnt, 32'd0);
    endtask

    // Assert reset mid-cycle, check everything is cleared, release on a falling edge.
    task automatic do_reset(input string nm);
        exp_valid = 1'b0;
        @(posedge clock); #3;
        reset = 1'b0;
        #1 check_all_zero(nm);
        mem_ready = 1'b0;
        exp_cnt   = 32'd0;
        exp_ill   = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
    endtask

    // Per-cycle comparison against the planned expectation.
    always @(negedge clock) begin
        if (exp_valid) begin
            obs_st.push_back(state);
            if (state == 4'd2) begin
                last_aop = aluop;
                last_ie  = if_extend;
            end
            chk("strobes", 32'({state, pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                                reg_write, reg_dst, mem_to_reg, alu_src, if_extend,
                                aluop, retire}), 32'(exp_cur));
            chk("instr_cnt", instr_cnt, exp_cnt);
            chk("illegal", 32'(illegal), 32'(exp_ill));
        end
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b1; op = '0; funct = '0; zero = 1'b0;
        exp_valid = 1'b0; exp_cnt = '0; exp_ill = 1'b0; exp_cur = '0;
        last_aop = '0; last_ie = 1'b0;
        #12 check_all_zero("reset");
        mem_ready = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        // addu: FETCH, DECODE, EXEC, WB
        run_instr(6'h00, 6'h21, 1'b0, 0, 0);
        chk("addu_len", 32'(obs_st.size()), 32'd4);
        if (obs_st.size() == 4) begin
            chk("addu_st0", 32'(obs_st[0]), 32'd0);
            chk("addu_st1", 32'(obs_st[1]), 32'd1);
            chk("addu_st2", 32'(obs_st[2]), 32'd2);
            chk("addu_st3", 32'(obs_st[3]), 32'd5);
        end
        chk("addu_cnt", instr_cnt, 32'd1);
        chk("addu_next", 32'(state), 32'd0);

        // lw with two wait cycles in MEM_RD
        run_instr(6'h23, 6'h00, 1'b0, 0, 2);
        chk("lw_cycles", 32'(obs_st.size()), 32'd7);
        chk("lw_cnt", instr_cnt, 32'd2);

        // beq taken then not taken
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        chk("beq_cnt", instr_cnt, 32'd4);

        // ori (imm 0x8000 -> funct bits 0) then addiu
        run_instr(6'h0d, 6'h00, 1'b0, 0, 0);
        chk("ori_aluop", 32'(last_aop), 32'd3);
        chk("ori_ext", 32'(last_ie), 32'd0);
        run_instr(6'h09, 6'h00, 1'b0, 0, 0);
        chk("addiu_aluop", 32'(last_aop), 32'd0);
        chk("addiu_ext", 32'(last_ie), 32'd1);

        // remaining ALU ops, with fetch waits mixed in
        run_instr(6'h00, 6'h23, 1'b0, 1, 0);
        chk("subu_aluop", 32'(last_aop), 32'd1);
        run_instr(6'h00, 6'h24, 1'b1, 0, 0);
        run_instr(6'h00, 6'h25, 1'b0, 2, 0);
        run_instr(6'h00, 6'h2a, 1'b0, 0, 0);
        chk("slt_aluop", 32'(last_aop), 32'd4);
        run_instr(6'h0f, 6'h00, 1'b0, 0, 0);
        chk("lui_aluop", 32'(last_aop), 32'd5);
        run_instr(6'h2b, 6'h00, 1'b0, 0, 1);
        chk("sw_cycles", 32'(obs_st.size()), 32'd5);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        chk("mix_cnt", instr_cnt, 32'd13);

        // reset in the middle of a MEM_WR wait
        op = 6'h2b; funct = 6'h00; zero = 1'b0;
        build(6'h2b, 6'h00, 1'b0, 0, 5, 0);
        run_plan(5);
        chk("sw_wait_st", 32'(state), 32'd4);
        do_reset("rst_memwr");
        chk("post_rst_mr", 32'(mem_read), 32'd1);
        chk("post_rst_st", 32'(state), 32'd0);
        run_instr(6'h00, 6'h21, 1'b0, 0, 0);
        chk("post_rst_cnt", instr_cnt, 32'd1);

        // op=0 with unknown funct traps
        run_instr(6'h00, 6'h00, 1'b0, 0, 0);
        chk("badfn_ill", 32'(illegal), 32'd1);
        chk("badfn_st", 32'(state), 32'd8);
        do_reset("rst_trap");

        // op=0x3f traps and stays put for 100 cycles
        run_instr(6'h00, 6'h25, 1'b0, 0, 0);
        op = 6'h3f; funct = 6'h00;
        build(6'h3f, 6'h00, 1'b0, 0, 0, 100);
        run_plan(-1);
        chk("trap_ill", 32'(illegal), 32'd1);
        chk("trap_st", 32'(state), 32'd8);
        chk("trap_cnt", instr_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
